// File: rtl/pipe_ctl_pkg.sv
// Shared types and encodings for the five-stage pipeline sequencing controller.
package pipe_ctl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned CTL_W = 7;

  localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  typedef enum logic [2:0] {
    HZ_RUN      = 3'd0,
    HZ_MEMWAIT  = 3'd1,
    HZ_BRANCH   = 3'd2,
    HZ_LOADUSE  = 3'd3,
    HZ_MDUSTALL = 3'd4
  } hazard_e;

  // Pipeline register controls, bundled so each hazard maps to one constant.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = pipe_ctrl_t'(7'b11111_00);
  localparam pipe_ctrl_t CTRL_FREEZE = pipe_ctrl_t'(7'b00000_00);
  localparam pipe_ctrl_t CTRL_BRANCH = pipe_ctrl_t'(7'b11111_11);
  localparam pipe_ctrl_t CTRL_STALL  = pipe_ctrl_t'(7'b00111_01);
  localparam pipe_ctrl_t CTRL_RESET  = pipe_ctrl_t'(7'b00000_11);

  // EX operand source; the younger producer in MEM wins over WB.
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] mem_rd,
    input logic             mem_we,
    input logic [REG_W-1:0] wb_rd,
    input logic             wb_we
  );
    logic [FWD_W-1:0] sel;
    sel = FWD_REG;
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// Busy timer for the multi-cycle multiply/divide unit.
module mdu_timer
  import pipe_ctl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  output logic busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A start while already counting is ignored; the stall logic upstream prevents it.
  always_comb begin
    cnt_d = cnt_q;
    if (start && (cnt_q == '0)) begin
      cnt_d = div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctl.sv
// Hazard resolution, stall/flush sequencing and EX forwarding for the MIPS32 pipeline.
module pipe_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_mdu_use,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             ex_mdu_start,
  input  logic             ex_mdu_div,
  input  logic             branch_taken,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  input  logic             dmem_wait,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             mdu_busy
);

  hazard_e    hz_c;
  pipe_ctrl_t ctl_c;
  logic       load_use_c;
  logic       mdu_stall_c;
  logic       busy;

  mdu_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ex_mdu_start),
    .div   (ex_mdu_div),
    .busy  (busy)
  );

  assign mdu_busy = busy;

  // Register $0 never carries a load result, so it cannot create a dependency.
  always_comb begin
    load_use_c  = ex_memread && (ex_rd != '0) &&
                  ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    mdu_stall_c = id_mdu_use && (busy || ex_mdu_start);
  end

  always_comb begin
    hz_c = HZ_RUN;
    if (dmem_wait) begin
      hz_c = HZ_MEMWAIT;
    end else if (branch_taken) begin
      hz_c = HZ_BRANCH;
    end else if (load_use_c) begin
      hz_c = HZ_LOADUSE;
    end else if (mdu_stall_c) begin
      hz_c = HZ_MDUSTALL;
    end
  end

  // Reset overrides every hazard: nothing loads and both bubbles are injected.
  always_comb begin
    ctl_c = CTRL_RUN;
    case (hz_c)
      HZ_MEMWAIT:  ctl_c = CTRL_FREEZE;
      HZ_BRANCH:   ctl_c = CTRL_BRANCH;
      HZ_LOADUSE:  ctl_c = CTRL_STALL;
      HZ_MDUSTALL: ctl_c = CTRL_STALL;
      default:     ctl_c = CTRL_RUN;
    endcase
    if (!rst_n) begin
      ctl_c = CTRL_RESET;
    end
  end

  assign pc_en      = ctl_c.pc_en;
  assign ifid_en    = ctl_c.ifid_en;
  assign idex_en    = ctl_c.idex_en;
  assign exmem_en   = ctl_c.exmem_en;
  assign memwb_en   = ctl_c.memwb_en;
  assign ifid_flush = ctl_c.ifid_flush;
  assign idex_flush = ctl_c.idex_flush;

  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (rst_n) begin
      fwd_a = fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      fwd_b = fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end
  end

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed and randomized checks of pipe_ctl against a cycle-count MDU model.
module tb_pipe_ctl;

  localparam int MUL_L = 4;
  localparam int DIV_L = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, id_mdu_use, ex_memread, ex_mdu_start, ex_mdu_div;
  logic       branch_taken, mem_regwrite, wb_regwrite, dmem_wait;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mdu_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [11:0] obs;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int m_issue = 0;
  int m_lat = 0;
  bit m_valid = 0;

  always #5 clk = ~clk;

  pipe_ctl #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_mdu_use(id_mdu_use), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_mdu_start(ex_mdu_start), .ex_mdu_div(ex_mdu_div),
    .branch_taken(branch_taken), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .dmem_wait(dmem_wait),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_busy(mdu_busy)
  );

  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                fwd_a, fwd_b, mdu_busy};

  // MDU issued at edge number m_issue stays busy through edge m_issue + L - 2.
  function automatic bit m_busy();
    return m_valid && ((cyc - m_issue) <= (m_lat - 2));
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [6:0] ctl;
    bit lu, ms, b;
    b = m_busy();
    if (!rst_n) return {7'b00000_11, 4'b0000, 1'b0};
    lu = ex_memread && ex_rd != 0 &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    ms = id_mdu_use && (b || ex_mdu_start);
    if (dmem_wait)         ctl = 7'b00000_00;
    else if (branch_taken) ctl = 7'b11111_11;
    else if (lu || ms)     ctl = 7'b00111_01;
    else                   ctl = 7'b11111_00;
    return {ctl, ref_fwd(ex_rs), ref_fwd(ex_rt), b};
  endfunction

  task automatic check(input string tag);
    logic [11:0] e;
    #1;
    e = exp_vec();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    bit was_busy, st, dv;
    was_busy = m_busy();
    st = ex_mdu_start;
    dv = ex_mdu_div;
    @(posedge clk);
    cyc++;
    if (!rst_n) m_valid = 0;
    else if (st && !was_busy) begin
      m_valid = 1;
      m_issue = cyc;
      m_lat = dv ? DIV_L : MUL_L;
    end
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    id_use_rs = 0; id_use_rt = 0; id_mdu_use = 0; ex_memread = 0;
    ex_mdu_start = 0; ex_mdu_div = 0; branch_taken = 0;
    mem_regwrite = 0; wb_regwrite = 0; dmem_wait = 0;
  endtask

  initial begin
    int stalls, busy_cnt;
    bit released;

    rst_n = 0;
    idle();
    mem_regwrite = 1; mem_rd = 5; ex_rs = 5; ex_rt = 5;
    check("reset_t0");
    tick();
    check("reset_edge");
    rst_n = 1;
    idle();
    check("run_idle");

    // Load-use on rs, then the load leaves EX
    ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    check("loaduse_stall");
    chk("loaduse_pc_en", pc_en, 0);
    tick();
    ex_memread = 0; ex_rd = 0;
    check("loaduse_release");
    ex_memread = 1; ex_rd = 0; id_rs = 0;
    check("loaduse_r0");
    chk("loaduse_r0_pc_en", pc_en, 1);
    tick();
    idle();

    // Forwarding priority
    mem_rd = 5; wb_rd = 5; ex_rs = 5; mem_regwrite = 1; wb_regwrite = 1;
    check("fwd_mem");
    chk("fwd_mem_a", fwd_a, 2);
    mem_regwrite = 0;
    check("fwd_wb");
    chk("fwd_wb_a", fwd_a, 1);
    ex_rs = 0;
    check("fwd_r0");
    ex_rt = 5; mem_regwrite = 1;
    check("fwd_b_mem");
    tick();
    idle();

    // Branch beats load-use
    ex_memread = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1; branch_taken = 1;
    check("branch_over_lu");
    chk("branch_pc_en", pc_en, 1);
    tick();
    idle();

    // Divide followed by a dependent mflo held in ID
    id_mdu_use = 1; ex_mdu_start = 1; ex_mdu_div = 1;
    stalls = 0; busy_cnt = 0; released = 0;
    for (int i = 0; i < 40 && !released; i++) begin
      check("div_seq");
      if (mdu_busy === 1'b1) busy_cnt++;
      if (pc_en === 1'b0) stalls++;
      else released = 1;
      if (!released) begin
        tick();
        ex_mdu_start = 0;
      end
    end
    chk("div_stall_cycles", stalls, 32);
    chk("div_busy_cycles", busy_cnt, 31);
    chk("div_released", int'(released), 1);
    tick();
    idle();

    // Multiply with a 3-cycle memory wait overlapping the busy window
    ex_mdu_start = 1;
    check("mul_issue");
    tick();
    ex_mdu_start = 0; dmem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      check("mul_memwait");
      chk("mul_wait_busy", mdu_busy, 1);
      tick();
    end
    dmem_wait = 0;
    check("mul_expired");
    chk("mul_expired_busy", mdu_busy, 0);
    idle();

    // Asynchronous reset in the middle of a divide
    ex_mdu_start = 1; ex_mdu_div = 1;
    check("div2_issue");
    tick();
    ex_mdu_start = 0; ex_mdu_div = 0;
    for (int i = 0; i < 5; i++) tick();
    check("div2_busy");
    #2;
    rst_n = 0;
    m_valid = 0;
    #1;
    chk("rst_async_busy", mdu_busy, 0);
    check("rst_async_ctl");
    tick();
    check("rst_hold");
    rst_n = 1;
    check("rst_release");
    tick();

    // Randomized traffic; starts only when the model says the MDU is idle
    for (int i = 0; i < 600; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom_range(0, 1)); id_use_rt = 1'($urandom_range(0, 1));
      id_mdu_use = ($urandom_range(0, 2) == 0);
      ex_memread = ($urandom_range(0, 2) == 0);
      ex_mdu_start = !m_busy() && ($urandom_range(0, 5) == 0);
      ex_mdu_div = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
      dmem_wait = ($urandom_range(0, 7) == 0);
      check("rand");
      if (ex_mdu_start) chk("start_while_busy", mdu_busy, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
